// File: rtl/sram_like_axi_bridge_pkg.sv
// Shared types and AXI constants for the sram-like to AXI3 single-beat bridge.
package sram_like_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_RD_ADDR      = 3'd1,
        ST_RD_DATA      = 3'd2,
        ST_WR_ADDR_DATA = 3'd3,
        ST_WR_RESP      = 3'd4
    } state_e;

    // Fixed AXI attributes; the wrapper ties these onto the id/len/burst pins.
    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_BYTE  = 3'b000;
    localparam logic [2:0] AXI_SIZE_HALF  = 3'b001;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/sram_like_axi_bridge.sv
// One sram-like request channel turned into single-beat AXI3 reads/writes,
// one transaction outstanding at a time.
module sram_like_axi_bridge
    import sram_like_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    // sram-like side
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  addr_ok,
    output logic                  data_ok,
    output logic [DATA_W-1:0]     rdata,
    // AXI read channels
    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  rvalid,
    output logic                  rready,
    // AXI write channels
    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bvalid,
    output logic                  bready,
    // FSM state for checkers
    output state_e                dbg_state
);

    // Handshake rule on every channel: a transfer happens on a rising edge where
    // valid and ready are both high; a valid stays high (payload frozen) until
    // its transfer, and ready never waits on anything but the FSM state.

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [1:0]            size_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_W-1:0]     rdata_q;
    logic                  data_ok_q, data_ok_d;
    logic                  accept;
    logic                  rd_capture;

    always_comb begin
        state_d    = state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        data_ok_d  = 1'b0;
        rd_capture = 1'b0;
        accept     = 1'b0;
        addr_ok    = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                addr_ok   = req;
                accept    = req;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (req) begin
                    state_d = wr ? ST_WR_ADDR_DATA : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    rd_capture = 1'b1;
                    data_ok_d  = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_WR_ADDR_DATA: begin
                // AW and W complete independently, in any order or together.
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_ok_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            data_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            data_ok_q <= data_ok_d;
            if (accept) begin
                addr_q  <= addr;
                size_q  <= size;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (rd_capture) begin
                rdata_q <= m_rdata;
            end
        end
    end

    assign data_ok   = data_ok_q;
    assign rdata     = rdata_q;
    assign araddr    = addr_q;
    assign awaddr    = addr_q;
    assign arsize    = axi_size(size_q);
    assign awsize    = axi_size(size_q);
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign dbg_state = state_q;

endmodule
